// File: rtl/hwag_cap_filter_if.sv
// Signal bundle between the tooth-sensor front-end and its controller: control inputs,
// filtered level, edge strobe and period capture outputs.
interface hwag_cap_filter_if #(
  parameter int FILT_WIDTH = 8,
  parameter int PER_WIDTH  = 24
);
  logic                  ena;
  logic                  cap_in;
  logic                  edge_sel;
  logic [FILT_WIDTH-1:0] filt_len;
  logic                  cap_out;
  logic                  cap_edge;
  logic [PER_WIDTH-1:0]  cap_period;
  logic                  cap_vld;
  logic                  cap_ovf;

  modport master (
    output ena, cap_in, edge_sel, filt_len,
    input  cap_out, cap_edge, cap_period, cap_vld, cap_ovf
  );

  modport slave (
    input  ena, cap_in, edge_sel, filt_len,
    output cap_out, cap_edge, cap_period, cap_vld, cap_ovf
  );
endinterface

// File: rtl/hwag_cap_filter.sv
// Crank/cam tooth input conditioner: synchroniser, glitch filter, selectable edge strobe
// and saturating tooth-period measurement between qualified edges.
module hwag_cap_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_WIDTH  = 8,
  parameter int PER_WIDTH   = 24
) (
  input logic              clk,
  input logic              arst,
  input logic              srst,
  hwag_cap_filter_if.slave bus
);

  function automatic logic [FILT_WIDTH-1:0] sat_inc_filt(input logic [FILT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PER_WIDTH-1:0] sat_inc_per(input logic [PER_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p1;
  logic [FILT_WIDTH-1:0]  filt_cnt_p1;
  logic                   level_p1;
  logic [PER_WIDTH-1:0]   per_cnt_p1;
  logic                   armed_p1;
  logic                   edge_p2;
  logic                   vld_p2;
  logic [PER_WIDTH-1:0]   period_p2;
  logic                   ovf_p2;

  logic [FILT_WIDTH:0]    len_eff;
  logic [FILT_WIDTH:0]    cnt_next;
  logic                   flip;
  logic                   qual;

  assign s_p1 = sync_p0[SYNC_STAGES-1];

  // Filter decision: ">=" lets a shortened filt_len take effect on the next mismatch sample
  always_comb begin
    len_eff  = (bus.filt_len == '0) ? (FILT_WIDTH+1)'(1) : {1'b0, bus.filt_len};
    cnt_next = {1'b0, filt_cnt_p1} + (FILT_WIDTH+1)'(1);
    flip     = bus.ena && (s_p1 != level_p1) && (cnt_next >= len_eff);
    qual     = flip && (bus.edge_sel ? level_p1 : ~level_p1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_p0     <= '0;
      filt_cnt_p1 <= '0;
      level_p1    <= 1'b0;
      per_cnt_p1  <= '0;
      armed_p1    <= 1'b0;
      edge_p2     <= 1'b0;
      vld_p2      <= 1'b0;
      period_p2   <= '0;
      ovf_p2      <= 1'b0;
    end else if (srst) begin
      sync_p0     <= '0;
      filt_cnt_p1 <= '0;
      level_p1    <= 1'b0;
      per_cnt_p1  <= '0;
      armed_p1    <= 1'b0;
      edge_p2     <= 1'b0;
      vld_p2      <= 1'b0;
      period_p2   <= '0;
      ovf_p2      <= 1'b0;
    end else begin
      // Stage 0: synchroniser keeps running while ena is low
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.cap_in};

      // Stage 1: glitch filter and period counter
      if (bus.ena) begin
        if (s_p1 == level_p1) begin
          filt_cnt_p1 <= '0;
        end else if (flip) begin
          level_p1    <= s_p1;
          filt_cnt_p1 <= '0;
        end else begin
          filt_cnt_p1 <= sat_inc_filt(filt_cnt_p1);
        end

        if (qual) begin
          per_cnt_p1 <= '0;
          armed_p1   <= 1'b1;
        end else begin
          per_cnt_p1 <= sat_inc_per(per_cnt_p1);
        end
      end

      // Stage 2: strobes and period capture; first edge after reset only arms
      edge_p2 <= qual;
      vld_p2  <= qual && armed_p1;
      if (qual && armed_p1) begin
        period_p2 <= sat_inc_per(per_cnt_p1);
        ovf_p2    <= ovf_p2 | (&per_cnt_p1);
      end
    end
  end

  assign bus.cap_out    = level_p1;
  assign bus.cap_edge   = edge_p2;
  assign bus.cap_vld    = vld_p2;
  assign bus.cap_period = period_p2;
  assign bus.cap_ovf    = ovf_p2;

endmodule
